// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// FSM state encoding, grant codes and default widths.
package mem_arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin chooser: on a tie the requester
// that was not granted last wins. Ports: req0/req1/last in, valid/winner out.
module rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the CPU (m0) and loader (m1).
// Ports: m0_*/m1_* requester handshakes, mem_* memory side, clk, reset.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          grant, last_grant;
  logic          we_q, err_q;
  logic [DW-1:0] rdata_q;
  logic          pick_valid, pick_winner;
  logic          tmo;

  rr_pick u_pick (
    .req0   (m0_req),
    .req1   (m1_req),
    .last   (last_grant),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign tmo = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (pick_valid) nxt = BUSY;
      BUSY:    if (mem_ack || tmo) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      grant      <= M0;
      last_grant <= M1;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant      <= pick_winner;
            last_grant <= pick_winner;
            cnt        <= '0;
            we_q       <= pick_winner ? m1_we    : m0_we;
            mem_addr   <= pick_winner ? m1_addr  : m0_addr;
            mem_wdata  <= pick_winner ? m1_wdata : m0_wdata;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          // ack beats a simultaneous timeout
          if (mem_ack) begin
            rdata_q <= we_q ? '0 : mem_rdata;
            err_q   <= 1'b0;
          end else if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en   = (state == BUSY);
    mem_we   = mem_en & we_q;
    m0_ready = (state == RESP) & (grant == M0);
    m1_ready = (state == RESP) & (grant == M1);
    m0_rdata = m0_ready ? rdata_q : '0;
    m1_rdata = m1_ready ? rdata_q : '0;
    m0_err   = m0_ready & err_q;
    m1_err   = m1_ready & err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 0, m0_we = 0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_ready, m0_err;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 0, m1_we = 0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_ready, m1_err;
  logic [DW-1:0] m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int   checks = 0;
  int   errors = 0;
  logic last_g = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in the IDLE cycle with requests set (cycle 0).
  // Acks in cycle d (0 = never), returns in the ready cycle.
  task automatic run_txn(
    input  int            d,
    input  logic [DW-1:0] ad,
    input  bit            scramble,
    output int            rc,
    output logic          r0,
    output logic          r1,
    output logic          e,
    output logic [DW-1:0] rd,
    output int            en_n,
    output logic [AW-1:0] a1,
    output logic [DW-1:0] w1,
    output logic          we1,
    output bit            stable
  );
    rc = -1; en_n = 0; stable = 1'b1;
    r0 = 0; r1 = 0; e = 0; rd = '0;
    a1 = '0; w1 = '0; we1 = 1'b0;
    mem_rdata = ad;
    for (int c = 1; c <= 40; c++) begin
      step();
      mem_ack = 1'b0;
      if (mem_en) begin
        en_n++;
        if (en_n == 1) begin
          a1 = mem_addr; w1 = mem_wdata; we1 = mem_we;
        end else if (mem_addr !== a1 || mem_wdata !== w1
                     || mem_we !== we1) begin
          stable = 1'b0;
        end
      end
      if (m0_ready || m1_ready) begin
        rc = c; r0 = m0_ready; r1 = m1_ready;
        e  = m0_ready ? m0_err : m1_err;
        rd = m0_ready ? m0_rdata : m1_rdata;
        break;
      end
      if (scramble) begin
        m0_addr = $urandom; m0_wdata = $urandom;
        m1_addr = $urandom; m1_wdata = $urandom;
        m0_we = 1'($urandom); m1_we = 1'($urandom);
      end
      mem_ack = (c == d);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({m0_ready, m0_err, m0_rdata, m1_ready, m1_err, m1_rdata,
         mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outs in reset: en=%b addr=%h r0=%b r1=%b exp all 0",
               mem_en, mem_addr, m0_ready, m1_ready);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({m0_ready, m1_ready, mem_en, mem_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle got %b exp 0000",
               {m0_ready, m1_ready, mem_en, mem_we});
    end
    last_g = 1'b1;
  endtask

  task automatic test_single_read();
    int rc, en_n; logic r0, r1, e, we1; bit st;
    logic [DW-1:0] rd, w1; logic [AW-1:0] a1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    run_txn(1, 32'hDEADBEEF, 0, rc, r0, r1, e, rd, en_n, a1, w1, we1, st);
    m0_req = 0;
    checks++;
    if (rc !== 2) begin errors++;
      $display("FAIL rd_latency got %0d exp 2", rc); end
    checks++;
    if ({r0, r1, e} !== 3'b100) begin errors++;
      $display("FAIL rd_flags got %b exp 100", {r0, r1, e}); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++;
      $display("FAIL rd_data got %h exp deadbeef", rd); end
    checks++;
    if (a1 !== 32'h10 || we1 !== 1'b0) begin errors++;
      $display("FAIL rd_cmd got %h/%b exp 10/0", a1, we1); end
    last_g = 1'b0;
    step();
  endtask

  task automatic test_tie();
    int rc, en_n; logic r0, r1, e, we1; bit st;
    logic [DW-1:0] rd, w1; logic [AW-1:0] a1;
    logic win;
    // fresh reset so the first tie goes to m0
    reset = 1; step(); reset = 0; last_g = 1'b1; step();
    m0_req = 1; m0_we = 0; m0_addr = 32'hA0;
    m1_req = 1; m1_we = 0; m1_addr = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      win = ~last_g;
      run_txn(1, $urandom, 0, rc, r0, r1, e, rd, en_n, a1, w1, we1, st);
      checks++;
      if (a1 !== (win ? 32'hB0 : 32'hA0) || {r1, r0} !== (win ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL tie_%0d got addr %h rdy %b%b exp m%0d", i, a1, r1, r0, win);
      end
      last_g = win;
      if (i < 3) step();
    end
    m0_req = 0; m1_req = 0;
    step();
  endtask

  task automatic test_write_wait();
    int rc, en_n; logic r0, r1, e, we1; bit st;
    logic [DW-1:0] rd, w1; logic [AW-1:0] a1;
    m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h1234;
    run_txn(5, 32'hCAFE0001, 1, rc, r0, r1, e, rd, en_n, a1, w1, we1, st);
    m1_req = 0;
    checks++;
    if (rc !== 6 || en_n !== 5) begin errors++;
      $display("FAIL wr_timing got rc %0d en %0d exp 6 5", rc, en_n); end
    checks++;
    if (a1 !== 32'h40 || w1 !== 32'h1234 || we1 !== 1'b1 || !st) begin
      errors++;
      $display("FAIL wr_cmd got %h %h we %b stable %0d exp 40 1234 1 1",
               a1, w1, we1, st);
    end
    checks++;
    if ({r0, r1, e} !== 3'b010 || rd !== '0) begin errors++;
      $display("FAIL wr_resp got %b rd %h exp 010 0", {r0, r1, e}, rd); end
    last_g = 1'b1;
    step();
  endtask

  task automatic test_timeout();
    int rc, en_n; logic r0, r1, e, we1; bit st;
    logic [DW-1:0] rd, w1; logic [AW-1:0] a1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h80;
    run_txn(0, 32'h5555AAAA, 0, rc, r0, r1, e, rd, en_n, a1, w1, we1, st);
    m0_req = 0;
    checks++;
    if (rc !== TO + 1 || en_n !== TO) begin errors++;
      $display("FAIL tmo_timing got rc %0d en %0d exp %0d %0d",
               rc, en_n, TO + 1, TO); end
    checks++;
    if ({r0, r1, e} !== 3'b101 || rd !== '0) begin errors++;
      $display("FAIL tmo_resp got %b rd %h exp 101 0", {r0, r1, e}, rd); end
    last_g = 1'b0;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({mem_en, m0_ready, m1_ready} !== 3'b000) begin errors++;
        $display("FAIL late_ack got %b exp 000", {mem_en, m0_ready, m1_ready}); end
      step();
    end
  endtask

  task automatic test_ack_boundary();
    int rc, en_n; logic r0, r1, e, we1; bit st;
    logic [DW-1:0] rd, w1; logic [AW-1:0] a1;
    logic [DW-1:0] v;
    v = $urandom | 32'h1;
    m0_req = 1; m0_we = 0; m0_addr = 32'hC4;
    run_txn(TO, v, 0, rc, r0, r1, e, rd, en_n, a1, w1, we1, st);
    m0_req = 0;
    checks++;
    if (rc !== TO + 1 || e !== 1'b0 || rd !== v || r0 !== 1'b1) begin
      errors++;
      $display("FAIL ack_edge got rc %0d err %b rd %h exp %0d 0 %h",
               rc, e, rd, TO + 1, v);
    end
    last_g = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_busy();
    int rc, en_n; logic r0, r1, e, we1; bit st;
    logic [DW-1:0] rd, w1; logic [AW-1:0] a1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h20;
    repeat (3) step();
    checks++;
    if (mem_en !== 1'b1) begin errors++;
      $display("FAIL rst_busy got en %b exp 1", mem_en); end
    reset = 1; m0_req = 0;
    step();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_en, mem_we, m0_ready, m1_ready} !== 4'b0) begin errors++;
        $display("FAIL rst_abort_%0d got %b exp 0000", i,
                 {mem_en, mem_we, m0_ready, m1_ready}); end
      step();
    end
    last_g = 1'b1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h24;
    m1_req = 1; m1_we = 0; m1_addr = 32'h28;
    run_txn(2, $urandom, 0, rc, r0, r1, e, rd, en_n, a1, w1, we1, st);
    m0_req = 0; m1_req = 0;
    checks++;
    if (a1 !== 32'h24 || {r0, r1} !== 2'b10 || rc !== 3) begin errors++;
      $display("FAIL rst_tie got addr %h rdy %b%b rc %0d exp 24 10 3",
               a1, r0, r1, rc); end
    last_g = 1'b0;
    step();
  endtask

  task automatic test_random();
    int rc, en_n; logic r0, r1, e, we1; bit st;
    logic [DW-1:0] rd, w1; logic [AW-1:0] a1;
    logic [1:0] p; int d; logic win, hit;
    logic [AW-1:0] xa [2]; logic [DW-1:0] xw [2]; logic xe [2];
    logic [DW-1:0] v;
    for (int n = 0; n < 25; n++) begin
      p = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        xa[k] = $urandom; xw[k] = $urandom; xe[k] = 1'($urandom);
      end
      m0_req = p[0]; m0_addr = xa[0]; m0_wdata = xw[0]; m0_we = xe[0];
      m1_req = p[1]; m1_addr = xa[1]; m1_wdata = xw[1]; m1_we = xe[1];
      d = $urandom_range(1, TO + 3);
      v = $urandom;
      win = (p == 2'b11) ? ~last_g : p[1];
      hit = (d <= TO);
      run_txn(d, v, 1, rc, r0, r1, e, rd, en_n, a1, w1, we1, st);
      m0_req = 0; m1_req = 0;
      checks++;
      if (rc !== (hit ? d + 1 : TO + 1) || en_n !== rc - 1) begin errors++;
        $display("FAIL rnd_%0d_timing got rc %0d en %0d exp %0d", n, rc,
                 en_n, hit ? d + 1 : TO + 1); end
      checks++;
      if ({r1, r0} !== (win ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL rnd_%0d_grant got %b%b exp m%0d", n, r1, r0, win); end
      checks++;
      if (a1 !== xa[win] || w1 !== xw[win] || we1 !== xe[win] || !st) begin
        errors++;
        $display("FAIL rnd_%0d_cmd got %h %h %b st %0d exp %h %h %b",
                 n, a1, w1, we1, st, xa[win], xw[win], xe[win]);
      end
      checks++;
      if (e !== ~hit || rd !== ((hit && !xe[win]) ? v : '0)) begin errors++;
        $display("FAIL rnd_%0d_resp got err %b rd %h exp %b %h", n, e, rd,
                 ~hit, (hit && !xe[win]) ? v : 32'h0); end
      last_g = win;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_write_wait();
    test_timeout();
    test_ack_boundary();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-port unified memory between the multicycle CPU control path (requester 0: fetch, MemRead, MemWrite) and the program loader/debug port (requester 1). It issues one memory transaction at a time and returns read data with a one-cycle ready pulse. It also bounds every transaction with a timeout, so a missing memory acknowledge cannot hang the CPU state machine. It sits between the CPU address mux (adr_src) and the memory.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, maximum BUSY cycles allowed without mem_ack (must be ≥1)

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- m0_req  in  1  CPU request; held until m0_ready
- m0_we  in  1  CPU write (1) / read (0)
- m0_addr  in  AW  CPU address
- m0_wdata  in  DW  CPU write data
- m0_ready  out  1  one-cycle completion pulse to CPU
- m0_rdata  out  DW  read data, valid while m0_ready
- m0_err  out  1  timeout flag, valid while m0_ready
- m1_req, m1_we, m1_addr, m1_wdata, m1_ready, m1_rdata, m1_err: same as the m0 ports, for the loader
- mem_en  out  1  transaction active
- mem_we  out  1  write strobe
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched write data
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle

## Operation
- States: IDLE, BUSY, RESP. Reset → IDLE.
- Reset values: all outputs 0; cnt=0; last_grant=1; grant=0.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req, grant that requester.
  - If both req, grant the requester ≠ last_grant (round-robin).
  - On grant, latch we/addr/wdata into mem_* registers, set grant and last_grant, clear cnt, and go to BUSY.
- BUSY:
  - mem_en=1 and mem_we=latched we.
  - Increment cnt each cycle.
  - If mem_ack: capture mem_rdata into the rdata register (reads; writes capture 0), clear err, and go to RESP.
  - Else if cnt == TIMEOUT-1: set rdata=0 and err=1, and go to RESP.
- RESP:
  - mem_en=0.
  - Assert m{grant}_ready=1 with rdata/err for exactly one cycle.
  - The other requester's outputs stay 0.
  - Go to IDLE. req is not sampled in RESP.
- Requester rule: req must be low in the cycle after its ready pulse. A still-high req is treated as a new request.
- mem_ack outside BUSY is ignored.
- mem_ack in the same cycle as the timeout condition: ack wins and err=0.
- mem_addr/mem_wdata are stable for the whole of BUSY. Requester inputs may change after the grant without effect.
- Synchronous reset in any state abandons the transaction: next cycle is IDLE, mem_en=0, no ready pulse.

## Timing
- Cycle 0: req seen in IDLE.
- Cycle 1: BUSY, mem_en high.
- Ack in BUSY cycle k (k≥1) → RESP and ready at cycle k+1.
- Minimum latency req→ready is 2 cycles; the minimum transaction occupancy is 3 cycles (IDLE, BUSY, RESP).
- Timeout: BUSY lasts exactly TIMEOUT cycles, and ready+err arrives at cycle TIMEOUT+1.
- Back-to-back: the next grant is decided in the IDLE cycle after RESP. Sustained throughput is one transaction per 3+ cycles.
- Outputs are registered; there is no combinational path from req to mem_*.

## Structure
- Package mem_arb_pkg holds:
  - state encoding: IDLE=2'd0, BUSY=2'd1, RESP=2'd2
  - grant codes: M0=1'b0, M1=1'b1
  - default widths AW/DW
- Sub-module rr_pick: combinational 2-way round-robin chooser with inputs req0, req1, last and outputs valid, winner. Kept separate so it can later grow to N requesters.
- The top module holds the FSM, cnt (width $clog2(TIMEOUT+1)), the command/rdata/err registers, and the ready demux.

## Test plan
- Single read: m0_req, we=0, addr=0x10; mem_ack with rdata=0xDEADBEEF in the 1st BUSY cycle → m0_ready at cycle 2, m0_rdata=0xDEADBEEF, err=0, m1_ready=0.
- Tie after reset: m0_req and m1_req both high at cycle 0 → m0 granted first (mem_addr=m0_addr). With both held, m1 is granted in the next IDLE, then m0. Strict alternation over 4 transactions.
- Write with wait states: m1 write, addr=0x40, wdata=0x1234; mem_ack after 5 BUSY cycles → mem_we=1 and addr/wdata stable for all 5 cycles; m1_ready at cycle 6.
- Timeout: m0 read, no mem_ack, TIMEOUT=15 → mem_en high for exactly 15 cycles; m0_ready=1, m0_err=1, rdata=0 at cycle 16. A late mem_ack at cycle 17 is ignored.
- Ack at the timeout boundary: mem_ack in the 15th BUSY cycle → err=0 and rdata is the captured value.
- Reset mid-BUSY: reset at BUSY cycle 3 → next cycle IDLE, mem_en=0, no ready pulse, last_grant=1; a subsequent tie grants m0.
